// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings for the decode stage: instruction classes, opcodes and
// the ALU / memory / jump operation codes carried in the control bundle.
package pipelined_control_unit_pkg;

  typedef enum logic [1:0] {
    CLS_R   = 2'b00,
    CLS_I   = 2'b01,
    CLS_MEM = 2'b10,
    CLS_JMP = 2'b11
  } op_class_e;

  // Function field (low opcode bits) per class
  localparam logic [3:0] FN_ADD  = 4'h0, FN_SUB  = 4'h1, FN_AND  = 4'h2, FN_OR   = 4'h3;
  localparam logic [3:0] FN_XOR  = 4'h4, FN_SLL  = 4'h5, FN_SRL  = 4'h6, FN_SLT  = 4'h7;
  localparam logic [3:0] FN_ADDI = 4'h0, FN_SUBI = 4'h1, FN_ANDI = 4'h2, FN_ORI  = 4'h3;
  localparam logic [3:0] FN_XORI = 4'h4, FN_MOVI = 4'h5;
  localparam logic [3:0] FN_LW   = 4'h0, FN_SW   = 4'h1, FN_LA   = 4'h2, FN_SA   = 4'h3;
  localparam logic [3:0] FN_JMP  = 4'h0, FN_JE   = 4'h1, FN_JNE  = 4'h2, FN_JLT  = 4'h3;
  localparam logic [3:0] FN_JGT  = 4'h4;

  localparam logic [5:0] OP_CODE_ADD  = {CLS_R, FN_ADD},   OP_CODE_SUB  = {CLS_R, FN_SUB};
  localparam logic [5:0] OP_CODE_AND  = {CLS_R, FN_AND},   OP_CODE_OR   = {CLS_R, FN_OR};
  localparam logic [5:0] OP_CODE_XOR  = {CLS_R, FN_XOR},   OP_CODE_SLL  = {CLS_R, FN_SLL};
  localparam logic [5:0] OP_CODE_SRL  = {CLS_R, FN_SRL},   OP_CODE_SLT  = {CLS_R, FN_SLT};
  localparam logic [5:0] OP_CODE_ADDI = {CLS_I, FN_ADDI},  OP_CODE_SUBI = {CLS_I, FN_SUBI};
  localparam logic [5:0] OP_CODE_ANDI = {CLS_I, FN_ANDI},  OP_CODE_ORI  = {CLS_I, FN_ORI};
  localparam logic [5:0] OP_CODE_XORI = {CLS_I, FN_XORI},  OP_CODE_MOVI = {CLS_I, FN_MOVI};
  localparam logic [5:0] OP_CODE_LW   = {CLS_MEM, FN_LW},  OP_CODE_SW   = {CLS_MEM, FN_SW};
  localparam logic [5:0] OP_CODE_LA   = {CLS_MEM, FN_LA},  OP_CODE_SA   = {CLS_MEM, FN_SA};
  localparam logic [5:0] OP_CODE_JMP  = {CLS_JMP, FN_JMP}, OP_CODE_JE   = {CLS_JMP, FN_JE};
  localparam logic [5:0] OP_CODE_JNE  = {CLS_JMP, FN_JNE}, OP_CODE_JLT  = {CLS_JMP, FN_JLT};
  localparam logic [5:0] OP_CODE_JGT  = {CLS_JMP, FN_JGT};

  localparam logic [5:0] ALU_OP_NOP = 6'd0, ALU_OP_ADD = 6'd1, ALU_OP_SUB  = 6'd2;
  localparam logic [5:0] ALU_OP_AND = 6'd3, ALU_OP_OR  = 6'd4, ALU_OP_XOR  = 6'd5;
  localparam logic [5:0] ALU_OP_SLL = 6'd6, ALU_OP_SRL = 6'd7, ALU_OP_SLT  = 6'd8;
  localparam logic [5:0] ALU_OP_MOVI = 6'd9;

  localparam logic [1:0] MEM_OP_NOP = 2'd0, MEM_OP_READ = 2'd1, MEM_OP_WRITE = 2'd2;

  localparam logic [3:0] JMP_OP_NOP = 4'd0, JMP_OP_JMP = 4'd1, JMP_OP_JE  = 4'd2;
  localparam logic [3:0] JMP_OP_JNE = 4'd3, JMP_OP_JLT = 4'd4, JMP_OP_JGT = 4'd5;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Instruction-in / control-bundle-out handshake bus of the decode stage.
interface pipelined_control_unit_if #(
  parameter int OP_CODE_BITS  = 6,
  parameter int REG_ADDR_BITS = 5,
  parameter int ALU_OP_BITS   = 6,
  parameter int MEM_OP_BITS   = 2,
  parameter int JUMP_BITS     = 4,
  parameter int CNT_BITS      = 16
) ();
  import pipelined_control_unit_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [OP_CODE_BITS-1:0]  opcode;
  logic [REG_ADDR_BITS-1:0] rs;
  logic [REG_ADDR_BITS-1:0] rt;
  logic [REG_ADDR_BITS-1:0] rd;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic                     reg_dst;
  logic [REG_ADDR_BITS-1:0] dst_reg;
  logic [MEM_OP_BITS-1:0]   mem_op;
  logic                     mem_to_reg;
  logic [ALU_OP_BITS-1:0]   alu_op;
  logic                     alu_src;
  logic                     reg_write;
  logic                     address_src;
  logic [JUMP_BITS-1:0]     jop;
  logic                     illegal;
  logic [CNT_BITS-1:0]      stall_count;

  modport master (
    output in_valid, opcode, rs, rt, rd, flush, out_ready,
    input  in_ready, out_valid, reg_dst, dst_reg, mem_op, mem_to_reg, alu_op,
    input  alu_src, reg_write, address_src, jop, illegal, stall_count
  );

  modport slave (
    input  in_valid, opcode, rs, rt, rd, flush, out_ready,
    output in_ready, out_valid, reg_dst, dst_reg, mem_op, mem_to_reg, alu_op,
    output alu_src, reg_write, address_src, jop, illegal, stall_count
  );

endinterface

// File: rtl/pipelined_control_unit_decode.sv
// Purely combinational opcode -> control bundle decoder. Undefined opcodes
// raise illegal and force every bundle field back to its NOP value.
module control_decode
  import pipelined_control_unit_pkg::*;
#(
  parameter int OP_CODE_BITS  = 6,
  parameter int REG_ADDR_BITS = 5,
  parameter int ALU_OP_BITS   = 6,
  parameter int MEM_OP_BITS   = 2,
  parameter int JUMP_BITS     = 4
) (
  input  logic [OP_CODE_BITS-1:0]  opcode,
  input  logic [REG_ADDR_BITS-1:0] rt,
  input  logic [REG_ADDR_BITS-1:0] rd,
  output logic                     reg_dst,
  output logic [REG_ADDR_BITS-1:0] dst_reg,
  output logic [MEM_OP_BITS-1:0]   mem_op,
  output logic                     mem_to_reg,
  output logic [ALU_OP_BITS-1:0]   alu_op,
  output logic                     alu_src,
  output logic                     reg_write,
  output logic                     address_src,
  output logic [JUMP_BITS-1:0]     jop,
  output logic                     illegal
);
  localparam int FN_W = OP_CODE_BITS - 2;

  op_class_e       cls_s;
  logic [FN_W-1:0] fn_s;

  assign cls_s = op_class_e'(opcode[OP_CODE_BITS-1 -: 2]);
  assign fn_s  = opcode[FN_W-1:0];

  // Class defaults first, then per-function fields, then illegal override
  always_comb begin
    reg_dst     = 1'b0;
    dst_reg     = '0;
    mem_op      = MEM_OP_BITS'(MEM_OP_NOP);
    mem_to_reg  = 1'b0;
    alu_op      = ALU_OP_BITS'(ALU_OP_NOP);
    alu_src     = 1'b0;
    reg_write   = 1'b0;
    address_src = 1'b0;
    jop         = JUMP_BITS'(JMP_OP_NOP);
    illegal     = 1'b0;
    case (cls_s)
      CLS_R: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        case (fn_s)
          FN_W'(FN_ADD): alu_op = ALU_OP_BITS'(ALU_OP_ADD);
          FN_W'(FN_SUB): alu_op = ALU_OP_BITS'(ALU_OP_SUB);
          FN_W'(FN_AND): alu_op = ALU_OP_BITS'(ALU_OP_AND);
          FN_W'(FN_OR):  alu_op = ALU_OP_BITS'(ALU_OP_OR);
          FN_W'(FN_XOR): alu_op = ALU_OP_BITS'(ALU_OP_XOR);
          FN_W'(FN_SLL): alu_op = ALU_OP_BITS'(ALU_OP_SLL);
          FN_W'(FN_SRL): alu_op = ALU_OP_BITS'(ALU_OP_SRL);
          FN_W'(FN_SLT): alu_op = ALU_OP_BITS'(ALU_OP_SLT);
          default:       illegal = 1'b1;
        endcase
      end
      CLS_I: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        case (fn_s)
          FN_W'(FN_ADDI): alu_op = ALU_OP_BITS'(ALU_OP_ADD);
          FN_W'(FN_SUBI): alu_op = ALU_OP_BITS'(ALU_OP_SUB);
          FN_W'(FN_ANDI): alu_op = ALU_OP_BITS'(ALU_OP_AND);
          FN_W'(FN_ORI):  alu_op = ALU_OP_BITS'(ALU_OP_OR);
          FN_W'(FN_XORI): alu_op = ALU_OP_BITS'(ALU_OP_XOR);
          FN_W'(FN_MOVI): alu_op = ALU_OP_BITS'(ALU_OP_MOVI);
          default:        illegal = 1'b1;
        endcase
      end
      CLS_MEM: begin
        mem_to_reg = 1'b1;
        case (fn_s)
          FN_W'(FN_LW): begin
            mem_op    = MEM_OP_BITS'(MEM_OP_READ);
            reg_write = 1'b1;
          end
          FN_W'(FN_LA): begin
            mem_op      = MEM_OP_BITS'(MEM_OP_READ);
            reg_write   = 1'b1;
            address_src = 1'b1;
          end
          FN_W'(FN_SW): mem_op = MEM_OP_BITS'(MEM_OP_WRITE);
          FN_W'(FN_SA): begin
            mem_op      = MEM_OP_BITS'(MEM_OP_WRITE);
            address_src = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      CLS_JMP: begin
        case (fn_s)
          FN_W'(FN_JMP): jop = JUMP_BITS'(JMP_OP_JMP);
          FN_W'(FN_JE):  jop = JUMP_BITS'(JMP_OP_JE);
          FN_W'(FN_JNE): jop = JUMP_BITS'(JMP_OP_JNE);
          FN_W'(FN_JLT): jop = JUMP_BITS'(JMP_OP_JLT);
          FN_W'(FN_JGT): jop = JUMP_BITS'(JMP_OP_JGT);
          default:       illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      reg_dst     = 1'b0;
      dst_reg     = '0;
      mem_op      = MEM_OP_BITS'(MEM_OP_NOP);
      mem_to_reg  = 1'b0;
      alu_op      = ALU_OP_BITS'(ALU_OP_NOP);
      alu_src     = 1'b0;
      reg_write   = 1'b0;
      address_src = 1'b0;
      jop         = JUMP_BITS'(JMP_OP_NOP);
    end else if (reg_dst) begin
      dst_reg = rd;
    end else begin
      dst_reg = rt;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode pipeline stage: registers the decoded control bundle behind a
// valid/ready handshake, bubbles once per load-use pair and honours flush.
module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int OP_CODE_BITS  = 6,
  parameter int REG_ADDR_BITS = 5,
  parameter int ALU_OP_BITS   = 6,
  parameter int MEM_OP_BITS   = 2,
  parameter int JUMP_BITS     = 4,
  parameter int CNT_BITS      = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_control_unit_if.slave bus
);
  localparam int FN_W = OP_CODE_BITS - 2;

  logic                     dec_reg_dst_s, dec_mem_to_reg_s, dec_alu_src_s;
  logic                     dec_reg_write_s, dec_address_src_s, dec_illegal_s;
  logic [REG_ADDR_BITS-1:0] dec_dst_reg_s;
  logic [MEM_OP_BITS-1:0]   dec_mem_op_s;
  logic [ALU_OP_BITS-1:0]   dec_alu_op_s;
  logic [JUMP_BITS-1:0]     dec_jop_s;

  logic                     out_valid_r, reg_dst_r, mem_to_reg_r, alu_src_r;
  logic                     reg_write_r, address_src_r, illegal_r;
  logic [REG_ADDR_BITS-1:0] dst_reg_r;
  logic [MEM_OP_BITS-1:0]   mem_op_r;
  logic [ALU_OP_BITS-1:0]   alu_op_r;
  logic [JUMP_BITS-1:0]     jop_r;
  logic [CNT_BITS-1:0]      stall_count_r;

  op_class_e       in_cls_s;
  logic [FN_W-1:0] in_fn_s;
  logic            held_load_s, reads_rs_s, reads_rt_s, hazard_s;
  logic            in_ready_s, accept_s, consume_s;

  control_decode #(
    .OP_CODE_BITS (OP_CODE_BITS),
    .REG_ADDR_BITS(REG_ADDR_BITS),
    .ALU_OP_BITS  (ALU_OP_BITS),
    .MEM_OP_BITS  (MEM_OP_BITS),
    .JUMP_BITS    (JUMP_BITS)
  ) u_decode (
    .opcode     (bus.opcode),
    .rt         (bus.rt),
    .rd         (bus.rd),
    .reg_dst    (dec_reg_dst_s),
    .dst_reg    (dec_dst_reg_s),
    .mem_op     (dec_mem_op_s),
    .mem_to_reg (dec_mem_to_reg_s),
    .alu_op     (dec_alu_op_s),
    .alu_src    (dec_alu_src_s),
    .reg_write  (dec_reg_write_s),
    .address_src(dec_address_src_s),
    .jop        (dec_jop_s),
    .illegal    (dec_illegal_s)
  );

  assign in_cls_s = op_class_e'(bus.opcode[OP_CODE_BITS-1 -: 2]);
  assign in_fn_s  = bus.opcode[FN_W-1:0];

  // Load-use hazard detection and handshake qualifiers
  always_comb begin
    held_load_s = out_valid_r && (mem_op_r == MEM_OP_BITS'(MEM_OP_READ))
                  && reg_write_r && (dst_reg_r != '0);
    reads_rs_s  = (in_cls_s != CLS_JMP);
    reads_rt_s  = (in_cls_s == CLS_R)
                  || ((in_cls_s == CLS_MEM)
                      && ((in_fn_s == FN_W'(FN_SW)) || (in_fn_s == FN_W'(FN_SA))));
    hazard_s    = bus.in_valid && held_load_s
                  && ((reads_rs_s && (bus.rs == dst_reg_r))
                      || (reads_rt_s && (bus.rt == dst_reg_r)));
    in_ready_s  = !bus.flush && !hazard_s && (!out_valid_r || bus.out_ready);
    accept_s    = bus.in_valid && in_ready_s;
    consume_s   = out_valid_r && bus.out_ready;
  end

  // Output bundle register and saturating bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      reg_dst_r     <= 1'b0;
      dst_reg_r     <= '0;
      mem_op_r      <= MEM_OP_BITS'(MEM_OP_NOP);
      mem_to_reg_r  <= 1'b0;
      alu_op_r      <= ALU_OP_BITS'(ALU_OP_NOP);
      alu_src_r     <= 1'b0;
      reg_write_r   <= 1'b0;
      address_src_r <= 1'b0;
      jop_r         <= JUMP_BITS'(JMP_OP_NOP);
      illegal_r     <= 1'b0;
      stall_count_r <= '0;
    end else if (bus.flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      reg_dst_r     <= dec_reg_dst_s;
      dst_reg_r     <= dec_dst_reg_s;
      mem_op_r      <= dec_mem_op_s;
      mem_to_reg_r  <= dec_mem_to_reg_s;
      alu_op_r      <= dec_alu_op_s;
      alu_src_r     <= dec_alu_src_s;
      reg_write_r   <= dec_reg_write_s;
      address_src_r <= dec_address_src_s;
      jop_r         <= dec_jop_s;
      illegal_r     <= dec_illegal_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
      if (hazard_s && (stall_count_r != {CNT_BITS{1'b1}})) begin
        stall_count_r <= stall_count_r + CNT_BITS'(1);
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.reg_dst     = reg_dst_r;
  assign bus.dst_reg     = dst_reg_r;
  assign bus.mem_op      = mem_op_r;
  assign bus.mem_to_reg  = mem_to_reg_r;
  assign bus.alu_op      = alu_op_r;
  assign bus.alu_src     = alu_src_r;
  assign bus.reg_write   = reg_write_r;
  assign bus.address_src = address_src_r;
  assign bus.jop         = jop_r;
  assign bus.illegal     = illegal_r;
  assign bus.stall_count = stall_count_r;

endmodule
